// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver:
// glyph table, special segment patterns and the converter state type.
// Segment patterns are active-low, bit order g..a (bit 6 = g, bit 0 = a).
package seg7_pkg;

  // All seven segments off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Only segment g lit, used to flag a decimal overflow.
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Binary-to-BCD converter states.
  typedef enum logic [1:0] {
    CVT_IDLE  = 2'd0,
    CVT_SHIFT = 2'd1,
    CVT_DONE  = 2'd2
  } cvt_state_e;

  // Hex nibble to active-low segment pattern (g..a), glyphs 0-9, A, b, C, d, E, F.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle).
// Handshake: start is a one-cycle request honoured only in IDLE, where bin is
// captured; busy is high for exactly 4*N_DIGITS cycles while shifting; done is
// a one-cycle pulse during which bcd and ovf hold the finished result.
// The BCD register carries two extra digits so overflow past N_DIGITS is seen.
module seg7_bin2bcd
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  ovf,
  output cvt_state_e            state
);

  localparam int BW   = 4 * N_DIGITS;
  localparam int BCDW = 4 * (N_DIGITS + 2);
  localparam int CW   = (BW > 1) ? $clog2(BW) : 1;

  cvt_state_e      r_state;
  logic [BW-1:0]   r_bin;
  logic [BCDW-1:0] r_bcd;
  logic [CW-1:0]   r_cnt;
  logic [BCDW-1:0] w_adj;

  // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
  function automatic logic [BCDW-1:0] dabble(input logic [BCDW-1:0] v);
    logic [BCDW-1:0] r;
    r = v;
    for (int k = 0; k < N_DIGITS + 2; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Adjusted BCD value feeding this cycle's shift.
  always_comb begin
    w_adj = dabble(r_bcd);
  end

  // Converter FSM: capture on start, shift 4*N_DIGITS bits, hold result one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CVT_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        CVT_IDLE: begin
          if (start) begin
            r_bin   <= bin;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= CVT_SHIFT;
          end
        end
        CVT_SHIFT: begin
          r_bcd <= {w_adj[BCDW-2:0], r_bin[BW-1]};
          r_bin <= {r_bin[BW-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(BW - 1)) r_state <= CVT_DONE;
        end
        CVT_DONE: begin
          r_state <= CVT_IDLE;
        end
        default: begin
          r_state <= CVT_IDLE;
        end
      endcase
    end
  end

  assign busy  = (r_state == CVT_SHIFT);
  assign done  = (r_state == CVT_DONE);
  assign bcd   = r_bcd[BW-1:0];
  assign ovf   = |r_bcd[BCDW-1:BW];
  assign state = r_state;

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode 7-segment driver. Scans N_DIGITS digits at SCAN_HZ
// per digit, showing the input word as hex or (via seg7_bin2bcd) as decimal.
// Inputs are snapshotted only at frame start (scan tick on the last digit).
// Optional feature: define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] dat,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  mode,
  output logic [N_DIGITS-1:0]   AN,
  output logic [7:0]            SEG,
  output logic                  ce1ms,
  output logic                  busy,
  output logic                  ovf
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW  = 4 * N_DIGITS;

  logic [PW-1:0]       r_pre;
  logic [IW-1:0]       r_idx;
  logic [DW-1:0]       r_disp;   // digits on show; doubles as the hex data shadow
  logic [N_DIGITS-1:0] r_dp_sh;
  logic                r_ovf;

  logic                w_ce;
  logic                w_last;
  logic                w_fs;
  logic                w_hex_load;
  logic                w_dec_start;
  logic [IW-1:0]       w_idx_nxt;
  logic [DW-1:0]       w_disp_nxt;
  logic [N_DIGITS-1:0] w_dp_nxt;
  logic                w_ovf_nxt;
  logic [3:0]          w_nib;
  logic [6:0]          w_glyph;
  logic [N_DIGITS-1:0] w_blank;
`ifdef SEG7_LZB_EN
  logic                w_nz_above;
`endif

  logic                w_busy;
  logic                w_done;
  logic [DW-1:0]       w_bcd;
  logic                w_cvt_ovf;
  cvt_state_e          w_cvt_state;

  assign w_ce        = (r_pre == PW'(DIV - 1));
  assign w_last      = (r_idx == IW'(N_DIGITS - 1));
  assign w_fs        = w_ce & w_last;
  assign w_hex_load  = w_fs & ~mode;
  assign w_dec_start = w_fs & mode;
  assign w_idx_nxt   = !w_ce ? r_idx : (w_last ? '0 : r_idx + 1'b1);

  // Next contents of the display/shadow registers. The output stage looks at
  // these so a hex snapshot shows on digit 0 straight after the frame start.
  assign w_disp_nxt = w_done ? w_bcd : (w_hex_load ? dat : r_disp);
  assign w_ovf_nxt  = w_done ? w_cvt_ovf : (w_hex_load ? 1'b0 : r_ovf);
  assign w_dp_nxt   = w_fs ? dp : r_dp_sh;

  assign ce1ms = w_ce;
  assign busy  = w_busy;
  assign ovf   = r_ovf;

  seg7_bin2bcd #(
    .N_DIGITS (N_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_dec_start),
    .bin   (dat),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd),
    .ovf   (w_cvt_ovf),
    .state (w_cvt_state)
  );

  // The result write-back strobe must coincide with the converter's DONE state.
  a_done_state : assert property (@(posedge clk) disable iff (!rst_n)
    w_done |-> (w_cvt_state == CVT_DONE));

  // Prescaler: free-running 0..DIV-1, the terminal count is the scan tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pre <= '0;
    else if (w_ce) r_pre <= '0;
    else r_pre <= r_pre + 1'b1;
  end

  // Digit scan index, advanced once per scan tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_idx <= '0;
    else r_idx <= w_idx_nxt;
  end

  // Display data, overflow flag and decimal-point shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp  <= '0;
      r_ovf   <= 1'b0;
      r_dp_sh <= '0;
    end else begin
      r_disp  <= w_disp_nxt;
      r_ovf   <= w_ovf_nxt;
      r_dp_sh <= w_dp_nxt;
    end
  end

  // Leading-zero blanking mask: a digit blanks when it and all above are zero.
  always_comb begin
    w_blank = '0;
`ifdef SEG7_LZB_EN
    w_nz_above = 1'b0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      w_nz_above = w_nz_above | (w_disp_nxt[4*i +: 4] != 4'h0);
      w_blank[i] = ~w_nz_above & ~w_ovf_nxt;
    end
`endif
  end

  // Glyph for the digit about to be driven; overflow dash wins over blanking.
  always_comb begin
    w_nib   = w_disp_nxt[4*w_idx_nxt +: 4];
    w_glyph = hex2seg(w_nib);
    if (w_ovf_nxt) w_glyph = SEG_DASH;
    else if (w_blank[w_idx_nxt]) w_glyph = SEG_BLANK;
  end

  // Registered pin drivers, refreshed once per scan tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AN  <= '1;
      SEG <= 8'hFF;
    end else if (w_ce) begin
      AN  <= ~(N_DIGITS'(1) << w_idx_nxt);
      SEG <= {~w_dp_nxt[w_idx_nxt], w_glyph};
    end
  end

endmodule
